// File: rtl/led_bank_arbiter_if.sv
// Requester-side handshake bundle for led_bank_arbiter: one valid/pattern/ticks/rotate lane
// per requester plus the one-hot accept pulse returned by the arbiter.
interface led_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [6*NUM_REQ-1:0] req_pattern;
  logic [8*NUM_REQ-1:0] req_ticks;
  logic [NUM_REQ-1:0]   req_rotate;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid, req_pattern, req_ticks, req_rotate,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_pattern, req_ticks, req_rotate,
    output req_ready
  );
endinterface

// File: rtl/led_bank_arbiter.sv
// Round-robin time-sharing of the 6-bit active-low LED bank among NUM_REQ requesters.
// Optional per-tick left rotation of the displayed pattern is built only with LED_BANK_ARB_ROTATE_EN.
module led_bank_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter logic [31:0] TICK_DIV = 32'd6_749_999
) (
  input  logic                       clk,
  input  logic                       rst,
  led_bank_arbiter_if.slave          req_if,
  output logic [5:0]                 led_n,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       done
);
  localparam int unsigned GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   count_q, count_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [5:0]    pattern_q, pattern_d;
  logic [5:0]    led_n_q, led_n_d;
  logic          busy_q, busy_d;
  logic [GW-1:0] grant_id_q, grant_id_d;

  logic [GW-1:0]      sel;
  logic [5:0]         pat_sel;
  logic [7:0]         ticks_sel;
  logic [7:0]         ticks_eff;
  logic               tick;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               done_c;

`ifdef LED_BANK_ARB_ROTATE_EN
  logic rotate_q, rotate_d;
  logic rot_sel;
`else
  logic unused_rotate;
  assign unused_rotate = ^req_if.req_rotate;
`endif

  // First valid requester strictly after the last grant, wrapping around.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic          hit;
    pick = last;
    hit  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!hit && valid[i] && (((32'(last) + k) % NUM_REQ) == i)) begin
          hit  = 1'b1;
          pick = GW'(i);
        end
      end
    end
    return pick;
  endfunction

  always_comb begin : arbitrate
    sel       = rr_pick(req_if.req_valid, grant_id_q);
    pat_sel   = '0;
    ticks_sel = '0;
`ifdef LED_BANK_ARB_ROTATE_EN
    rot_sel   = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == sel) begin
        pat_sel   = req_if.req_pattern[6*i +: 6];
        ticks_sel = req_if.req_ticks[8*i +: 8];
`ifdef LED_BANK_ARB_ROTATE_EN
        rot_sel   = req_if.req_rotate[i];
`endif
      end
    end
  end

  assign ticks_eff = (ticks_sel == 8'd0) ? 8'd1 : ticks_sel;
  assign tick      = (count_q == TICK_DIV);

  always_comb begin : next_state
    state_d     = state_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    pattern_d   = pattern_q;
    grant_id_d  = grant_id_q;
    led_n_d     = '1;
    busy_d      = 1'b0;
    req_ready_c = '0;
    done_c      = 1'b0;
`ifdef LED_BANK_ARB_ROTATE_EN
    rotate_d    = rotate_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req_if.req_valid) begin
          req_ready_c[sel] = 1'b1;
          pattern_d        = pat_sel;
          remaining_d      = ticks_eff;
          grant_id_d       = sel;
          count_d          = '0;
          led_n_d          = ~pat_sel;
          busy_d           = 1'b1;
          state_d          = S_SHOW;
`ifdef LED_BANK_ARB_ROTATE_EN
          rotate_d         = rot_sel;
`endif
        end
      end
      S_SHOW: begin
        busy_d  = 1'b1;
        led_n_d = ~pattern_q;
        count_d = tick ? 32'd0 : count_q + 32'd1;
        if (tick) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            done_c  = 1'b1;
            led_n_d = '1;
            state_d = S_GAP;
          end else begin
`ifdef LED_BANK_ARB_ROTATE_EN
            if (rotate_q) begin
              pattern_d = {pattern_q[4:0], pattern_q[5]};
              led_n_d   = ~{pattern_q[4:0], pattern_q[5]};
            end
`endif
          end
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      remaining_q <= '0;
      pattern_q   <= '0;
      led_n_q     <= '1;
      busy_q      <= 1'b0;
      grant_id_q  <= GW'(NUM_REQ - 1);
`ifdef LED_BANK_ARB_ROTATE_EN
      rotate_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      pattern_q   <= pattern_d;
      led_n_q     <= led_n_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
`ifdef LED_BANK_ARB_ROTATE_EN
      rotate_q    <= rotate_d;
`endif
    end
  end

  // Accept and slot-end pulses are same-cycle decodes; a reset cycle suppresses both.
  assign req_if.req_ready = req_ready_c & {NUM_REQ{~rst}};
  assign done             = done_c & ~rst;
  assign led_n            = led_n_q;
  assign busy             = busy_q;
  assign grant_id         = grant_id_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios then random traffic, checked every cycle
// against a slot-timeline model (accept cycle + tick count -> expected outputs).
module tb_led_bank_arbiter;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned GW       = 2;
  localparam logic [31:0] TICK_DIV = 32'd3;
  localparam int          TD1      = 4;
`ifdef LED_BANK_ARB_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    led_n;
  logic          busy;
  logic          done;
  logic [GW-1:0] grant_id;

  led_bank_arbiter_if #(.NUM_REQ(NUM_REQ)) req_if ();

  led_bank_arbiter #(.NUM_REQ(NUM_REQ), .TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_if   (req_if),
    .led_n    (led_n),
    .busy     (busy),
    .grant_id (grant_id),
    .done     (done)
  );

  always #5 clk = ~clk;

  // staged stimulus, applied just after each rising edge
  logic [NUM_REQ-1:0]   s_valid = '0;
  logic [6*NUM_REQ-1:0] s_pat   = '0;
  logic [8*NUM_REQ-1:0] s_ticks = '0;
  logic [NUM_REQ-1:0]   s_rot   = '0;
  logic                 s_rst   = 1'b1;
  bit                   auto_drop = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model: one slot at a time, described by accept cycle, length and captured values
  bit         m_active = 1'b0;
  int         m_a = 0;
  int         m_n = 1;
  logic [5:0] m_pat = '0;
  bit         m_rot = 1'b0;
  int         m_last = NUM_REQ - 1;

  int dut_acc_cyc[$];
  int dut_acc_id[$];
  int dut_done_cyc[$];

  function automatic logic [5:0] rotl(input logic [5:0] p, input int r);
    logic [11:0] d;
    d = {p, p} << (r % 6);
    return d[11:6];
  endfunction

  function automatic int rr_model(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [5:0] pat, input logic [7:0] t,
                         input logic rot, input logic v);
    s_pat[6*i +: 6]   = pat;
    s_ticks[8*i +: 8] = t;
    s_rot[i]          = rot;
    s_valid[i]        = v;
  endtask

  task automatic clear_log();
    dut_acc_cyc.delete();
    dut_acc_id.delete();
    dut_done_cyc.delete();
  endtask

  task automatic cycle();
    logic [5:0]         e_led;
    logic               e_busy;
    logic               e_done;
    logic [NUM_REQ-1:0] e_ready;
    int                 pick;
    int                 end_c;
    int                 t;
    @(posedge clk);
    #1;
    cyc++;
    rst                = s_rst;
    req_if.req_valid   = s_valid;
    req_if.req_pattern = s_pat;
    req_if.req_ticks   = s_ticks;
    req_if.req_rotate  = s_rot;
    @(negedge clk);
    e_led   = '1;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_ready = '0;
    pick    = -1;
    end_c   = m_a + m_n * TD1;
    if (m_active && cyc <= end_c + 1) begin
      e_busy = 1'b1;
      if (cyc <= end_c) begin
        e_led  = ~rotl(m_pat, m_rot ? (cyc - m_a - 1) / TD1 : 0);
        e_done = (cyc == end_c) && !s_rst;
      end
    end else if (!s_rst && s_valid != '0) begin
      pick = rr_model(s_valid, m_last);
      e_ready[pick] = 1'b1;
    end
    chk("led_n", 32'(led_n), 32'(e_led));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("req_ready", 32'(req_if.req_ready), 32'(e_ready));
    chk("grant_id", 32'(grant_id), 32'(m_last));
    if (req_if.req_ready != '0) begin
      dut_acc_cyc.push_back(cyc);
      for (int i = 0; i < NUM_REQ; i++) if (req_if.req_ready[i]) dut_acc_id.push_back(i);
    end
    if (done) dut_done_cyc.push_back(cyc);
    if (s_rst) begin
      m_active = 1'b0;
      m_last   = NUM_REQ - 1;
    end else if (pick >= 0) begin
      t        = int'(s_ticks[8*pick +: 8]);
      m_active = 1'b1;
      m_a      = cyc;
      m_n      = (t == 0) ? 1 : t;
      m_pat    = s_pat[6*pick +: 6];
      m_rot    = ROT_EN && s_rot[pick];
      m_last   = pick;
      if (auto_drop) s_valid[pick] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int rr_exp[6];
    rr_exp = '{0, 1, 3, 0, 1, 3};

    // reset and idle
    s_rst = 1'b1;
    run(3);
    s_rst = 1'b0;
    run(2);

    // single request, ticks 2
    clear_log();
    set_req(0, 6'b000001, 8'd2, 1'b0, 1'b1);
    run(12);
    chk("single_accepts", 32'(dut_acc_cyc.size()), 32'd1);
    chk("single_dones", 32'(dut_done_cyc.size()), 32'd1);
    if (dut_acc_cyc.size() >= 1 && dut_done_cyc.size() >= 1) begin
      chk("single_id", 32'(dut_acc_id[0]), 32'd0);
      chk("single_latency", 32'(dut_done_cyc[0] - dut_acc_cyc[0]), 32'd8);
    end

    // round robin from fresh reset
    s_rst = 1'b1;
    run(1);
    s_rst = 1'b0;
    clear_log();
    auto_drop = 1'b0;
    set_req(0, 6'b100001, 8'd1, 1'b0, 1'b1);
    set_req(1, 6'b010010, 8'd1, 1'b0, 1'b1);
    set_req(3, 6'b001100, 8'd1, 1'b0, 1'b1);
    run(34);
    s_valid = '0;
    run(6);
    auto_drop = 1'b1;
    chk("rr_accepts", 32'(dut_acc_cyc.size()), 32'd6);
    if (dut_acc_cyc.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("rr_order", 32'(dut_acc_id[k]), 32'(rr_exp[k]));
      for (int k = 0; k < 5; k++)
        chk("rr_spacing", 32'(dut_acc_cyc[k+1] - dut_acc_cyc[k]), 32'd6);
    end

    // zero ticks behaves as one
    clear_log();
    set_req(2, 6'b110011, 8'd0, 1'b0, 1'b1);
    run(8);
    chk("zero_dones", 32'(dut_done_cyc.size()), 32'd1);
    if (dut_acc_cyc.size() >= 1 && dut_done_cyc.size() >= 1)
      chk("zero_latency", 32'(dut_done_cyc[0] - dut_acc_cyc[0]), 32'd4);

    // rotation request
    clear_log();
    set_req(1, 6'b000011, 8'd3, 1'b1, 1'b1);
    run(16);
    chk("rot_dones", 32'(dut_done_cyc.size()), 32'd1);

    // reset five cycles into a ticks-3 slot
    clear_log();
    set_req(0, 6'b111000, 8'd3, 1'b0, 1'b1);
    run(5);
    s_rst = 1'b1;
    run(1);
    s_rst = 1'b0;
    chk("rst_no_done", 32'(dut_done_cyc.size()), 32'd0);
    set_req(0, 6'b000111, 8'd1, 1'b0, 1'b1);
    set_req(2, 6'b101000, 8'd1, 1'b0, 1'b1);
    run(14);
    chk("rst_accepts", 32'(dut_acc_id.size()), 32'd3);
    if (dut_acc_id.size() >= 2) chk("rst_next_grant", 32'(dut_acc_id[1]), 32'd0);

    // inputs change after accept
    clear_log();
    set_req(0, 6'b101010, 8'd2, 1'b0, 1'b1);
    run(1);
    set_req(0, 6'b010101, 8'd5, 1'b1, 1'b0);
    run(11);
    if (dut_acc_cyc.size() >= 1 && dut_done_cyc.size() >= 1)
      chk("frozen_latency", 32'(dut_done_cyc[0] - dut_acc_cyc[0]), 32'd8);
    else
      chk("frozen_events", 32'(dut_done_cyc.size()), 32'd1);

    // random traffic
    for (int t = 0; t < 800; t++) begin
      auto_drop = (t < 400);
      s_rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 9) == 0) s_valid[i] = ~s_valid[i];
        if ($urandom_range(0, 3) == 0) begin
          s_pat[6*i +: 6]   = 6'($urandom);
          s_ticks[8*i +: 8] = 8'($urandom_range(0, 3));
          s_rot[i]          = 1'($urandom);
        end
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
